// File: rtl/shift_arbiter.sv
// shift_arbiter: round-robin sequencer that shares one combinational barrel
// shifter between N_REQ requesters. One request is accepted, executed and
// returned before the next one is granted (IDLE -> EXEC -> RESP).
// Build option: define SHIFT_ARB_FLAGS_EN to register and return the zero and
// ASL-overflow flags; without it rsp_zf_out/rsp_vf_out are tied low.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Requesters hold valid and payload until accepted. The response
// payload is held stable while rsp_valid_out is high and rsp_ready_in is low.

module barrelshifter #(
    parameter int D_SIZE = 8
) (
    input  logic [D_SIZE-1:0]         i_x,
    input  logic [$clog2(D_SIZE)-1:0] i_s,
    input  logic [2:0]                i_op,
    output logic [D_SIZE-1:0]         o_y,
    output logic                      o_zf,
    output logic                      o_vf
);
    localparam int SW = $clog2(D_SIZE);
    localparam logic [SW:0] DW = (SW+1)'(D_SIZE);

    logic [SW:0]       w_inv;
    logic [D_SIZE-1:0] w_lsl;
    logic [D_SIZE-1:0] w_ror;
    logic [D_SIZE-1:0] w_rol;
    logic [D_SIZE-1:0] w_asl_back;

    // A shift by D_SIZE yields zero, so s=0 rotates return x unchanged.
    assign w_inv      = DW - {1'b0, i_s};
    assign w_lsl      = i_x << i_s;
    assign w_ror      = (i_x >> i_s) | (i_x << w_inv);
    assign w_rol      = (i_x << i_s) | (i_x >> w_inv);
    // Shifting back arithmetically recovers x only if no significant bit was lost.
    assign w_asl_back = $unsigned($signed(w_lsl) >>> i_s);

    // Select the result by op code; ASL keeps the sign bit in place.
    always_comb begin
        o_y  = '0;
        o_vf = 1'b0;
        case (i_op)
            3'b000:         o_y = i_x >> i_s;
            3'b001:         o_y = $unsigned($signed(i_x) >>> i_s);
            3'b010, 3'b011: o_y = w_ror;
            3'b100:         o_y = w_lsl;
            3'b101: begin
                o_y  = {i_x[D_SIZE-1], w_lsl[D_SIZE-2:0]};
                o_vf = (w_asl_back != i_x);
            end
            default:        o_y = w_rol;
        endcase
    end

    assign o_zf = (o_y == '0);
endmodule

module shift_arbiter #(
    parameter int D_SIZE = 8,
    parameter int N_REQ  = 4
) (
    input  logic                             clk_in,
    input  logic                             rst_n_in,
    input  logic [N_REQ-1:0]                 req_valid_in,
    output logic [N_REQ-1:0]                 req_ready_out,
    input  logic [N_REQ*D_SIZE-1:0]          req_x_in,
    input  logic [N_REQ*$clog2(D_SIZE)-1:0]  req_s_in,
    input  logic [N_REQ*3-1:0]               req_op_in,
    output logic                             rsp_valid_out,
    input  logic                             rsp_ready_in,
    output logic [$clog2(N_REQ)-1:0]         rsp_id_out,
    output logic [D_SIZE-1:0]                rsp_y_out,
    output logic                             rsp_zf_out,
    output logic                             rsp_vf_out,
    output logic                             busy_out
);
    localparam int SW  = $clog2(D_SIZE);
    localparam int IDW = $clog2(N_REQ);

    typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_RESP} state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [IDW-1:0]    r_last_grant;
    logic [D_SIZE-1:0] r_x;
    logic [SW-1:0]     r_s;
    logic [2:0]        r_op;
    logic [IDW-1:0]    r_id;
    logic [IDW-1:0]    r_rsp_id;
    logic [D_SIZE-1:0] r_y;
    logic [IDW-1:0]    w_win_id;
    logic              w_any_valid;
    logic              w_grant_en;
    logic              w_req_fire;
    logic [D_SIZE-1:0] w_bs_y;
    logic              w_bs_zf;
    logic              w_bs_vf;

    function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] base, input int k);
        int t;
        t = (int'(base) + k) % N_REQ;
        return IDW'(t);
    endfunction

    // Round-robin search upward from last_grant+1; the nearest valid requester wins.
    always_comb begin
        w_any_valid = 1'b0;
        w_win_id    = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            if (req_valid_in[rr_idx(r_last_grant, k)]) begin
                w_any_valid = 1'b1;
                w_win_id    = rr_idx(r_last_grant, k);
            end
        end
    end

    // Grants are masked while reset is asserted so ready reads low during reset.
    assign w_grant_en = (r_state == ST_IDLE) && rst_n_in;
    assign w_req_fire = w_grant_en && w_any_valid;

    // State register.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) r_state <= ST_IDLE;
        else           r_state <= w_next_state;
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_any_valid)  w_next_state = ST_EXEC;
            ST_EXEC:                   w_next_state = ST_RESP;
            ST_RESP: if (rsp_ready_in) w_next_state = ST_IDLE;
            default:                   w_next_state = ST_IDLE;
        endcase
    end

    // Output decode: one-hot grant in IDLE only, response valid in RESP.
    always_comb begin
        req_ready_out = '0;
        if (w_req_fire) req_ready_out = N_REQ'(1) << w_win_id;
        rsp_valid_out = (r_state == ST_RESP);
        busy_out      = (r_state != ST_IDLE);
    end

    // Operand capture on grant and result capture at the end of EXEC.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_last_grant <= IDW'(N_REQ - 1);
            r_x          <= '0;
            r_s          <= '0;
            r_op         <= '0;
            r_id         <= '0;
            r_rsp_id     <= '0;
            r_y          <= '0;
        end else begin
            if (w_req_fire) begin
                r_x          <= req_x_in[int'(w_win_id)*D_SIZE +: D_SIZE];
                r_s          <= req_s_in[int'(w_win_id)*SW +: SW];
                r_op         <= req_op_in[int'(w_win_id)*3 +: 3];
                r_id         <= w_win_id;
                r_last_grant <= w_win_id;
            end
            if (r_state == ST_EXEC) begin
                r_y      <= w_bs_y;
                r_rsp_id <= r_id;
            end
        end
    end

    // The shared shifter only ever sees the registered operands.
    barrelshifter #(.D_SIZE(D_SIZE)) u_bs (
        .i_x  (r_x),
        .i_s  (r_s),
        .i_op (r_op),
        .o_y  (w_bs_y),
        .o_zf (w_bs_zf),
        .o_vf (w_bs_vf)
    );

    assign rsp_id_out = r_rsp_id;
    assign rsp_y_out  = r_y;

`ifdef SHIFT_ARB_FLAGS_EN
    logic r_zf;
    logic r_vf;

    // Flags are captured together with y.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_zf <= 1'b0;
            r_vf <= 1'b0;
        end else if (r_state == ST_EXEC) begin
            r_zf <= w_bs_zf;
            r_vf <= w_bs_vf;
        end
    end

    assign rsp_zf_out = r_zf;
    assign rsp_vf_out = r_vf;
`else
    logic w_unused_flags;
    assign w_unused_flags = w_bs_zf | w_bs_vf;
    assign rsp_zf_out     = 1'b0;
    assign rsp_vf_out     = 1'b0;
`endif
endmodule

// File: tb/tb_shift_arbiter.sv
// Testbench for shift_arbiter (D_SIZE=8, N_REQ=4). Directed cases with
// constant expectations plus a negedge monitor that predicts grants and
// responses from the arbitration and shift rules; honours SHIFT_ARB_FLAGS_EN.

module tb_shift_arbiter;
    localparam int D  = 8;
    localparam int N  = 4;
    localparam int W  = 12;
`ifdef SHIFT_ARB_FLAGS_EN
    localparam bit FL = 1'b1;
`else
    localparam bit FL = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk_in = 1'b0;
    logic rst_n  = 1'b0;
    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready_out;
    logic [N*D-1:0] req_x     = '0;
    logic [N*3-1:0] req_s     = '0;
    logic [N*3-1:0] req_op    = '0;
    logic           rsp_valid_out;
    logic           rsp_ready = 1'b1;
    logic [1:0]     rsp_id_out;
    logic [D-1:0]   rsp_y_out;
    logic           rsp_zf_out;
    logic           rsp_vf_out;
    logic           busy_out;

    shift_arbiter #(.D_SIZE(D), .N_REQ(N)) dut (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n),
        .req_valid_in  (req_valid),
        .req_ready_out (req_ready_out),
        .req_x_in      (req_x),
        .req_s_in      (req_s),
        .req_op_in     (req_op),
        .rsp_valid_out (rsp_valid_out),
        .rsp_ready_in  (rsp_ready),
        .rsp_id_out    (rsp_id_out),
        .rsp_y_out     (rsp_y_out),
        .rsp_zf_out    (rsp_zf_out),
        .rsp_vf_out    (rsp_vf_out),
        .busy_out      (busy_out)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference shifter from the op definitions, using integer arithmetic.
    function automatic logic [9:0] ref_shift(input int x, input int s, input int op);
        int p, sx, y, q, r, pr;
        bit vf, zf;
        p  = 1 << s;
        sx = (x >= 128) ? x - 256 : x;
        y  = 0;
        vf = 1'b0;
        case (op)
            0: y = x / p;
            1: begin
                q = sx / p;
                if (sx < 0 && (sx % p) != 0) q = q - 1;
                y = q & 255;
            end
            2, 3: y = (x / p) + (x % p) * (256 / p);
            4: y = (x * p) % 256;
            5: begin
                y  = (x & 128) | ((x * p) % 128);
                vf = (sx * p > 127) || (sx * p < -128);
            end
            default: begin
                r  = (8 - s) % 8;
                pr = 1 << r;
                y  = (x / pr) + (x % pr) * (256 / pr);
            end
        endcase
        zf = (y == 0);
        return {8'(y), zf & FL, vf & FL};
    endfunction

    // ---------------- scoreboard / monitor ----------------
    logic [W-1:0] exp_q[$];
    int           g_id[$];
    int           g_cyc[$];
    int           m_stage = 0;
    int           m_last  = N - 1;
    logic [N-1:0] acc_seen = '0;

    // Predict grant and response timing from the round-robin rules; sample mid-cycle.
    always @(negedge clk_in) begin
        int w, idx;
        logic [9:0] r;
        logic [1:0] wid;
        logic [N-1:0] exp_rdy;
        if (!rst_n) begin
            check_eq("reset_outputs", 32'({req_ready_out, rsp_valid_out, rsp_id_out, rsp_y_out,
                                           rsp_zf_out, rsp_vf_out, busy_out}), 32'd0);
            m_stage  = 0;
            m_last   = N - 1;
            acc_seen = '0;
            exp_q.delete();
        end else begin
            acc_seen = req_valid & req_ready_out;
            for (int i = 0; i < N; i++)
                if (req_ready_out[i]) begin
                    g_id.push_back(i);
                    g_cyc.push_back(cyc);
                end
            case (m_stage)
                0: begin
                    w = -1;
                    for (int k = 1; k <= N; k++) begin
                        idx = (m_last + k) % N;
                        if (w < 0 && req_valid[idx]) w = idx;
                    end
                    exp_rdy = (w >= 0) ? (N'(1) << w) : '0;
                    check_eq("grant", 32'(req_ready_out), 32'(exp_rdy));
                    check_eq("idle_status", 32'({busy_out, rsp_valid_out}), 32'd0);
                    if (w >= 0) begin
                        r   = ref_shift(int'(req_x[w*D +: D]), int'(req_s[w*3 +: 3]),
                                        int'(req_op[w*3 +: 3]));
                        wid = w[1:0];
                        exp_q.push_back({wid, r});
                        m_last  = w;
                        m_stage = 1;
                    end
                end
                1: begin
                    check_eq("exec_status", 32'({req_ready_out, busy_out, rsp_valid_out}), 32'b0010);
                    m_stage = 2;
                end
                default: begin
                    check_eq("resp_status", 32'({req_ready_out, busy_out, rsp_valid_out}), 32'b0011);
                    if (exp_q.size() > 0)
                        check_eq("rsp_payload", 32'({rsp_id_out, rsp_y_out, rsp_zf_out, rsp_vf_out}),
                                 32'(exp_q[0]));
                    else
                        check_eq("rsp_unexpected", 32'd1, 32'd0);
                    if (rsp_ready) begin
                        void'(exp_q.pop_front());
                        m_stage = 0;
                    end
                end
            endcase
        end
    end

    // ---------------- driver ----------------
    bit auto_on   = 1'b0;
    bit auto_stop = 1'b0;
    bit rsp_rand  = 1'b0;
    int auto_pct  = 50;

    task automatic set_req(input int id, input int x, input int s, input int op);
        req_x[id*D +: D] = 8'(x);
        req_s[id*3 +: 3] = 3'(s);
        req_op[id*3 +: 3] = 3'(op);
        req_valid[id] = 1'b1;
    endtask

    // Advance one cycle; in auto mode refresh accepted or idle requesters.
    task automatic tick();
        @(posedge clk_in);
        #1;
        if (auto_on) begin
            for (int i = 0; i < N; i++)
                if (acc_seen[i] || !req_valid[i]) begin
                    if (!auto_stop && $urandom_range(0, 99) < auto_pct)
                        set_req(i, $urandom_range(0, 255), $urandom_range(0, 7), $urandom_range(0, 7));
                    else
                        req_valid[i] = 1'b0;
                end
            rsp_ready = rsp_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    endtask

    task automatic wait_grant(input int id);
        int n;
        n = 0;
        @(negedge clk_in);
        while (!req_ready_out[id] && n < 10) begin
            @(negedge clk_in);
            n++;
        end
        check_eq("grant_wait", 32'(req_ready_out), 32'(N'(1) << id));
    endtask

    // One isolated request with constant expectations; hold = RESP cycles with rsp_ready low.
    task automatic run_one(input int id, input int x, input int s, input int op,
                           input int ey, input bit ezf, input bit evf, input int hold);
        @(posedge clk_in);
        #1;
        rsp_ready = (hold == 0);
        set_req(id, x, s, op);
        wait_grant(id);
        @(posedge clk_in);
        #1;
        req_valid[id] = 1'b0;
        @(negedge clk_in);
        check_eq("lat_exec_no_valid", 32'({rsp_valid_out, busy_out}), 32'b01);
        @(negedge clk_in);
        check_eq("lat_resp_valid", 32'(rsp_valid_out), 32'd1);
        check_eq("rsp_id", 32'(rsp_id_out), 32'(id));
        check_eq("rsp_y", 32'(rsp_y_out), 32'(ey));
        check_eq("rsp_flags", 32'({rsp_zf_out, rsp_vf_out}), 32'({ezf & FL, evf & FL}));
        for (int h = 1; h < hold; h++) begin
            @(negedge clk_in);
            check_eq("bp_hold", 32'({rsp_valid_out, busy_out, req_ready_out, rsp_y_out, rsp_id_out}),
                     32'({1'b1, 1'b1, 4'b0, 8'(ey), 2'(id)}));
        end
        if (hold > 0) begin
            @(posedge clk_in);
            #1;
            rsp_ready = 1'b1;
            @(negedge clk_in);
            check_eq("bp_release_valid", 32'(rsp_valid_out), 32'd1);
        end
        @(negedge clk_in);
        check_eq("idle_after_rsp", 32'({busy_out, rsp_valid_out}), 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk_in);
        #1;
        req_valid = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        rst_n = 1'b1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        repeat (2) @(posedge clk_in);
        #1;
        rst_n = 1'b1;

        run_one(0, 8'h81, 1, 3'b001, 8'hC0, 1'b0, 1'b0, 0);   // ASR
        run_one(2, 8'h40, 1, 3'b101, 8'h00, 1'b1, 1'b1, 0);   // ASL overflow into zero
        run_one(3, 8'h81, 7, 3'b110, 8'hC0, 1'b0, 1'b0, 0);   // ROL wrap
        run_one(3, 8'h5A, 0, 3'b100, 8'h5A, 1'b0, 1'b0, 0);   // s=0
        run_one(1, 8'h01, 1, 3'b010, 8'h80, 1'b0, 1'b0, 0);   // ROR wrap
        run_one(1, 8'h0F, 2, 3'b000, 8'h03, 1'b0, 1'b0, 5);   // backpressure

        // Reset during EXEC of a req1 operation.
        @(posedge clk_in);
        #1;
        set_req(1, 8'h33, 1, 3'b100);
        wait_grant(1);
        @(posedge clk_in);
        #1;
        req_valid = '0;
        rst_n = 1'b0;
        #1;
        check_eq("reset_immediate", 32'({req_ready_out, rsp_valid_out, rsp_id_out, rsp_y_out,
                                          rsp_zf_out, rsp_vf_out, busy_out}), 32'd0);
        set_req(0, 8'h12, 4, 3'b000);
        set_req(1, 8'h80, 3, 3'b001);
        repeat (2) @(posedge clk_in);
        #1;
        rst_n = 1'b1;
        @(negedge clk_in);
        check_eq("reset_first_grant", 32'(req_ready_out), 32'b0001);
        @(posedge clk_in);
        #1;
        req_valid[0] = 1'b0;
        wait_grant(1);
        @(posedge clk_in);
        #1;
        req_valid[1] = 1'b0;
        repeat (6) @(negedge clk_in);

        // Fairness: everyone valid, consumer always ready.
        do_reset();
        g_id.delete();
        g_cyc.delete();
        auto_on  = 1'b1;
        auto_pct = 100;
        rsp_rand = 1'b0;
        repeat (22) tick();
        check_eq("fair_count_ok", 32'(g_id.size() >= 6), 32'd1);
        for (int k = 0; k < 6 && k < g_id.size(); k++) begin
            check_eq("fair_order", 32'(g_id[k]), 32'(k % N));
            if (k > 0) check_eq("fair_spacing", 32'(g_cyc[k] - g_cyc[k-1]), 32'd3);
        end

        // Random traffic with random response backpressure.
        auto_pct = 50;
        rsp_rand = 1'b1;
        repeat (400) tick();
        auto_stop = 1'b1;
        rsp_rand  = 1'b0;
        repeat (40) tick();
        check_eq("drain_empty", 32'(exp_q.size()), 32'd0);
        check_eq("drain_idle", 32'({busy_out, rsp_valid_out, req_valid}), 32'd0);
        auto_on = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
